// File: rtl/zbt_audio_pkg.sv
// Shared types and constants for the ZBT audio sample port: word/lane geometry,
// address width, read latency and the controller state encoding.
package zbt_audio_pkg;

  localparam int SAMPLES_PER_WORD = 3;
  localparam int SAMPLE_W         = 12;
  localparam int WORD_W           = SAMPLES_PER_WORD * SAMPLE_W;
  localparam int ADDR_W           = 19;
  localparam int READ_LATENCY     = 2;

  localparam logic [1:0]          LANE_LAST   = 2'(SAMPLES_PER_WORD - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_ZERO = 12'h000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REC       = 2'd1,
    ST_PLAY_FILL = 2'd2,
    ST_PLAY      = 2'd3
  } state_e;

  // Lane 0 sits in the most significant bits of the word.
  function automatic logic [SAMPLE_W-1:0] word_lane(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx);
    case (idx)
      2'd0:    word_lane = w[35:24];
      2'd1:    word_lane = w[23:12];
      2'd2:    word_lane = w[11:0];
      default: word_lane = SAMPLE_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/zbt_sample_port_if.sv
// ZBT SRAM access bundle: request strobe, direction, address, write and read data.
interface zbt_sample_port_if;
  import zbt_audio_pkg::*;

  logic              zbt_req;
  logic              zbt_we;
  logic [ADDR_W-1:0] zbt_addr;
  logic [WORD_W-1:0] zbt_wdata;
  logic [WORD_W-1:0] zbt_rdata;

  modport master (output zbt_req, zbt_we, zbt_addr, zbt_wdata, input zbt_rdata);
  modport slave  (input zbt_req, zbt_we, zbt_addr, zbt_wdata, output zbt_rdata);

endinterface

// File: rtl/zbt_read_pipe.sv
// Tracks outstanding ZBT reads: a LATENCY-deep valid shift register whose last
// stage marks the cycle zbt_rdata carries a requested word. Flush kills all.
module zbt_read_pipe
  import zbt_audio_pkg::*;
#(
  parameter int LATENCY = READ_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic issue,
  output logic rdata_valid
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;

  // Shift a new read in, or drop everything in flight on flush.
  always_comb begin
    if (flush) begin
      valid_d = {LATENCY{1'b0}};
    end else begin
      valid_d = {valid_q[LATENCY-2:0], issue};
    end
  end

  // Valid pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {LATENCY{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rdata_valid = valid_q[LATENCY-1];

endmodule

// File: rtl/zbt_sample_port.sv
// Packs record samples three per ZBT word and unpacks prefetched words on playback.
// Define ZBT_FLUSH_EN to write the partial word when song_done ends a recording.
module zbt_sample_port
  import zbt_audio_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_song,
  input  logic                pause_song,
  input  logic                record_mode,
  input  logic                song_done,
  input  logic [ADDR_W-1:0]   base_address,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                underrun,
  zbt_sample_port_if.master   zbt
);

  state_e              state_q, state_d;
  logic [1:0]          lane_idx_q, lane_idx_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [SAMPLE_W-1:0] lane0_q, lane0_d;
  logic [SAMPLE_W-1:0] lane1_q, lane1_d;
  logic [WORD_W-1:0]   cur_word_q, cur_word_d;
  logic                cur_valid_q, cur_valid_d;
  logic [WORD_W-1:0]   nxt_word_q, nxt_word_d;
  logic                nxt_valid_q, nxt_valid_d;
  logic                second_rd_q, second_rd_d;
  logic                done_pend_q, done_pend_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                underrun_q, underrun_d;
  logic                zbt_req_q, zbt_req_d;
  logic                zbt_we_q, zbt_we_d;
  logic [ADDR_W-1:0]   zbt_addr_q, zbt_addr_d;
  logic [WORD_W-1:0]   zbt_wdata_q, zbt_wdata_d;

  logic strobe_s;
  logic rdata_valid_s;

  assign strobe_s = sample_valid & ~pause_song;

  zbt_read_pipe #(.LATENCY(READ_LATENCY)) u_read_pipe (
    .clk         (clk),
    .rst_n       (reset),
    .flush       (start_song),
    .issue       (zbt_req_q & ~zbt_we_q),
    .rdata_valid (rdata_valid_s)
  );

  // Next-state, buffer and memory-request logic.
  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    word_addr_d  = word_addr_q;
    lane0_d      = lane0_q;
    lane1_d      = lane1_q;
    cur_word_d   = cur_word_q;
    cur_valid_d  = cur_valid_q;
    nxt_word_d   = nxt_word_q;
    nxt_valid_d  = nxt_valid_q;
    second_rd_d  = 1'b0;
    done_pend_d  = done_pend_q;
    sample_out_d = sample_out_q;
    underrun_d   = underrun_q;
    zbt_req_d    = 1'b0;
    zbt_we_d     = 1'b0;
    zbt_addr_d   = zbt_addr_q;
    zbt_wdata_d  = zbt_wdata_q;

    if (start_song) begin
      word_addr_d = base_address;
      lane_idx_d  = 2'd0;
      underrun_d  = 1'b0;
      cur_valid_d = 1'b0;
      nxt_valid_d = 1'b0;
      done_pend_d = 1'b0;
      if (record_mode) begin
        state_d = ST_REC;
      end else begin
        // Prime both buffer slots: base now, base+1 on the following cycle.
        state_d     = ST_PLAY_FILL;
        zbt_req_d   = 1'b1;
        zbt_addr_d  = base_address;
        word_addr_d = base_address + 19'd1;
        second_rd_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_REC: begin
          if (strobe_s) begin
            case (lane_idx_q)
              2'd0: begin
                lane0_d    = sample_in;
                lane_idx_d = 2'd1;
              end
              2'd1: begin
                lane1_d    = sample_in;
                lane_idx_d = 2'd2;
              end
              default: begin
                zbt_req_d   = 1'b1;
                zbt_we_d    = 1'b1;
                zbt_addr_d  = word_addr_q;
                zbt_wdata_d = {lane0_q, lane1_q, sample_in};
                word_addr_d = word_addr_q + 19'd1;
                lane_idx_d  = 2'd0;
              end
            endcase
          end else begin
            lane_idx_d = lane_idx_q;
          end
          if (song_done) begin
            state_d = ST_IDLE;
`ifdef ZBT_FLUSH_EN
            if (lane_idx_d != 2'd0) begin
              zbt_req_d   = 1'b1;
              zbt_we_d    = 1'b1;
              zbt_addr_d  = word_addr_q;
              zbt_wdata_d = {lane0_d, (lane_idx_d == 2'd2) ? lane1_d : SAMPLE_ZERO, SAMPLE_ZERO};
              word_addr_d = word_addr_q + 19'd1;
              lane_idx_d  = 2'd0;
            end else begin
              lane_idx_d = 2'd0;
            end
`else
            lane_idx_d = 2'd0;
`endif
          end else begin
            state_d = ST_REC;
          end
        end

        ST_PLAY_FILL, ST_PLAY: begin
          if (second_rd_q) begin
            zbt_req_d   = 1'b1;
            zbt_addr_d  = word_addr_q;
            word_addr_d = word_addr_q + 19'd1;
          end else begin
            zbt_req_d = 1'b0;
          end

          // Returning words fill the current slot first, then the prefetch slot.
          if (rdata_valid_s && !cur_valid_q) begin
            cur_word_d  = zbt.zbt_rdata;
            cur_valid_d = 1'b1;
          end else if (rdata_valid_s) begin
            nxt_word_d  = zbt.zbt_rdata;
            nxt_valid_d = 1'b1;
          end else begin
            nxt_valid_d = nxt_valid_q;
          end

          if (state_q == ST_PLAY_FILL) begin
            if (strobe_s) begin
              underrun_d = 1'b1;
            end else begin
              underrun_d = underrun_q;
            end
            if (rdata_valid_s) begin
              state_d = ST_PLAY;
            end else begin
              state_d = ST_PLAY_FILL;
            end
          end else begin
            if (song_done) begin
              done_pend_d = 1'b1;
            end else begin
              done_pend_d = done_pend_q;
            end

            if (strobe_s && !cur_valid_q) begin
              underrun_d = 1'b1;
            end else if (strobe_s) begin
              sample_out_d = word_lane(cur_word_q, lane_idx_q);
              if (lane_idx_q == LANE_LAST) begin
                lane_idx_d = 2'd0;
                if (nxt_valid_q) begin
                  cur_word_d  = nxt_word_q;
                  cur_valid_d = 1'b1;
                  nxt_valid_d = rdata_valid_s;
                end else if (rdata_valid_s) begin
                  cur_word_d  = zbt.zbt_rdata;
                  cur_valid_d = 1'b1;
                  nxt_valid_d = 1'b0;
                end else begin
                  cur_valid_d = 1'b0;
                  underrun_d  = 1'b1;
                end
                if (song_done || done_pend_q) begin
                  state_d = ST_IDLE;
                end else begin
                  zbt_req_d   = 1'b1;
                  zbt_addr_d  = word_addr_q;
                  word_addr_d = word_addr_q + 19'd1;
                end
              end else begin
                lane_idx_d = lane_idx_q + 2'd1;
              end
            end else begin
              sample_out_d = sample_out_q;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, buffer and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lane_idx_q   <= 2'd0;
      word_addr_q  <= 19'd0;
      lane0_q      <= 12'h000;
      lane1_q      <= 12'h000;
      cur_word_q   <= 36'h0;
      cur_valid_q  <= 1'b0;
      nxt_word_q   <= 36'h0;
      nxt_valid_q  <= 1'b0;
      second_rd_q  <= 1'b0;
      done_pend_q  <= 1'b0;
      sample_out_q <= 12'h000;
      underrun_q   <= 1'b0;
      zbt_req_q    <= 1'b0;
      zbt_we_q     <= 1'b0;
      zbt_addr_q   <= 19'd0;
      zbt_wdata_q  <= 36'h0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      word_addr_q  <= word_addr_d;
      lane0_q      <= lane0_d;
      lane1_q      <= lane1_d;
      cur_word_q   <= cur_word_d;
      cur_valid_q  <= cur_valid_d;
      nxt_word_q   <= nxt_word_d;
      nxt_valid_q  <= nxt_valid_d;
      second_rd_q  <= second_rd_d;
      done_pend_q  <= done_pend_d;
      sample_out_q <= sample_out_d;
      underrun_q   <= underrun_d;
      zbt_req_q    <= zbt_req_d;
      zbt_we_q     <= zbt_we_d;
      zbt_addr_q   <= zbt_addr_d;
      zbt_wdata_q  <= zbt_wdata_d;
    end
  end

  assign sample_out    = sample_out_q;
  assign underrun      = underrun_q;
  assign zbt.zbt_req   = zbt_req_q;
  assign zbt.zbt_we    = zbt_we_q;
  assign zbt.zbt_addr  = zbt_addr_q;
  assign zbt.zbt_wdata = zbt_wdata_q;

endmodule

// File: tb/tb_zbt_sample_port.sv
// Directed bench for zbt_sample_port: record packing, pause, partial-word flush,
// prefetched playback, underrun and reset during an outstanding read.
module tb_zbt_sample_port;
  import zbt_audio_pkg::*;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } acc_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start_song = 1'b0;
  logic                pause_song = 1'b0;
  logic                record_mode = 1'b0;
  logic                song_done = 1'b0;
  logic [ADDR_W-1:0]   base_address = 19'd0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = 12'h000;
  logic [SAMPLE_W-1:0] sample_out;
  logic                underrun;

  logic [WORD_W-1:0]   mem [0:15];
  logic                rd_v1 = 1'b0;
  logic [ADDR_W-1:0]   rd_a1 = 19'd0;
  acc_t                log_q[$];
  int                  tests = 0;
  int                  fails = 0;
  logic [SAMPLE_W-1:0] exp_play [0:5];

  zbt_sample_port_if zif ();

  zbt_sample_port dut (
    .clk          (clk),
    .reset        (reset),
    .start_song   (start_song),
    .pause_song   (pause_song),
    .record_mode  (record_mode),
    .song_done    (song_done),
    .base_address (base_address),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .underrun     (underrun),
    .zbt          (zif)
  );

  always #5 clk = ~clk;

  // Two-cycle read-latency SRAM model plus an access log; not reset on purpose.
  always @(posedge clk) begin
    rd_v1 <= zif.zbt_req && !zif.zbt_we;
    rd_a1 <= zif.zbt_addr;
    zif.zbt_rdata <= rd_v1 ? mem[rd_a1[3:0]] : 36'h0;
    if (zif.zbt_req) begin
      log_q.push_back('{we: zif.zbt_we, addr: zif.zbt_addr, data: zif.zbt_wdata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic [SAMPLE_W-1:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic rec);
    base_address = base;
    record_mode  = rec;
    start_song   = 1'b1;
    tick(1);
    start_song   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    log_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 36'h0;
    exp_play[0] = 12'hAAA; exp_play[1] = 12'hBBB; exp_play[2] = 12'hCCC;
    exp_play[3] = 12'hDDD; exp_play[4] = 12'hEEE; exp_play[5] = 12'hFFF;

    // Reset values
    do_reset();
    check("rst_sample_out", 36'(sample_out), 36'h0);
    check("rst_underrun", 36'(underrun), 36'h0);
    check("rst_req", 36'(zif.zbt_req), 36'h0);
    check("rst_we", 36'(zif.zbt_we), 36'h0);
    check("rst_addr", 36'(zif.zbt_addr), 36'h0);
    check("rst_wdata", zif.zbt_wdata, 36'h0);

    // Record: two full words at 240000 and 240001
    start(19'd240000, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      strobe(12'(i));
      tick(1);
    end
    tick(2);
    check("rec_count", 36'(log_q.size()), 36'd2);
    check("rec_w0_we", 36'(log_q[0].we), 36'd1);
    check("rec_w0_addr", 36'(log_q[0].addr), 36'd240000);
    check("rec_w0_data", log_q[0].data, 36'h001002003);
    check("rec_w1_we", 36'(log_q[1].we), 36'd1);
    check("rec_w1_addr", 36'(log_q[1].addr), 36'd240001);
    check("rec_w1_data", log_q[1].data, 36'h004005006);

    // Pause: paused strobes neither store nor advance the lane
    do_reset();
    start(19'd100, 1'b1);
    strobe(12'h011);
    strobe(12'h012);
    pause_song = 1'b1;
    strobe(12'h0EE);
    strobe(12'h0EF);
    strobe(12'h0F0);
    tick(2);
    check("pause_no_write", 36'(log_q.size()), 36'd0);
    pause_song = 1'b0;
    strobe(12'h013);
    tick(2);
    check("pause_count", 36'(log_q.size()), 36'd1);
    check("pause_addr", 36'(log_q[0].addr), 36'd100);
    check("pause_data", log_q[0].data, 36'h011012013);

    // Flush: four samples then song_done
    do_reset();
    start(19'd50, 1'b1);
    for (int i = 1; i <= 4; i++) strobe(12'(i));
    song_done = 1'b1;
    tick(1);
    song_done = 1'b0;
`ifdef ZBT_FLUSH_EN
    check("flush_req_next_cycle", 36'(zif.zbt_req), 36'd1);
`else
    check("flush_no_req", 36'(zif.zbt_req), 36'd0);
`endif
    tick(2);
    strobe(12'h007);
    strobe(12'h008);
    strobe(12'h009);
    tick(2);
    check("flush_w0_data", log_q[0].data, 36'h001002003);
    check("flush_w0_addr", 36'(log_q[0].addr), 36'd50);
`ifdef ZBT_FLUSH_EN
    check("flush_count", 36'(log_q.size()), 36'd2);
    check("flush_w1_we", 36'(log_q[1].we), 36'd1);
    check("flush_w1_addr", 36'(log_q[1].addr), 36'd51);
    check("flush_w1_data", log_q[1].data, 36'h004000000);
`else
    check("flush_count", 36'(log_q.size()), 36'd1);
`endif

    // Playback: prefetched words unpacked in order
    do_reset();
    mem[0] = 36'hAAABBBCCC;
    mem[1] = 36'hDDDEEEFFF;
    mem[2] = 36'h123456789;
    start(19'd0, 1'b0);
    tick(6);
    for (int i = 0; i < 6; i++) begin
      strobe(12'h555);
      check($sformatf("play_sample%0d", i), 36'(sample_out), 36'(exp_play[i]));
      tick(3);
    end
    check("play_underrun", 36'(underrun), 36'd0);
    check("play_read_count", 36'(log_q.size()), 36'd4);
    check("play_rd0_we", 36'(log_q[0].we), 36'd0);
    check("play_rd0_addr", 36'(log_q[0].addr), 36'd0);
    check("play_rd1_addr", 36'(log_q[1].addr), 36'd1);
    check("play_rd2_addr", 36'(log_q[2].addr), 36'd2);

    // Underrun: strobe one cycle after start, sticky until next start
    do_reset();
    start(19'd0, 1'b0);
    strobe(12'h000);
    check("udr_set", 36'(underrun), 36'd1);
    check("udr_sample_out", 36'(sample_out), 36'h0);
    tick(6);
    strobe(12'h000);
    check("udr_recover_sample", 36'(sample_out), 36'hAAA);
    check("udr_sticky", 36'(underrun), 36'd1);
    start(19'd0, 1'b0);
    check("udr_cleared_by_start", 36'(underrun), 36'd0);

    // Reset while a read is in flight; the late word must be ignored
    do_reset();
    mem[0] = 36'h5A55A55A5;
    start(19'd0, 1'b0);
    tick(1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", 36'(zif.zbt_req), 36'd0);
    check("mid_rst_addr", 36'(zif.zbt_addr), 36'd0);
    check("mid_rst_sample_out", 36'(sample_out), 36'h0);
    #1;
    reset = 1'b1;
    tick(4);
    check("mid_rst_idle_req", 36'(zif.zbt_req), 36'd0);
    strobe(12'h000);
    check("mid_rst_late_ignored", 36'(sample_out), 36'h0);
    check("mid_rst_underrun", 36'(underrun), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
